// File: rtl/moxie_wb_arbiter_pkg.sv
// Shared types for the moxie two-master Wishbone arbiter.
// State encodings, grant bit indices and counter sizing helper.
package moxie_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam int ARB_I = 0;
  localparam int ARB_D = 1;

  // Watchdog counter is kept between 8 and 16 bits wide
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/moxie_arb_watchdog.sv
// Stall watchdog: counts stalled strobe cycles, flags expiry.
// Instantiated only when MOXIE_ARB_TIMEOUT_EN is defined.
module moxie_arb_watchdog
  import moxie_wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic stall_i,
  output logic expired_o
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q >= LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (stall_i && !expired_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/moxie_wb_arbiter.sv
// Round-robin I/D Wishbone arbiter onto one slave port.
// Optional stall watchdog with err ports: MOXIE_ARB_TIMEOUT_EN.
module moxie_wb_arbiter
  import moxie_wb_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wbi_cyc_i,
  input  logic          wbi_stb_i,
  input  logic [AW-1:0] wbi_adr_i,
  output logic [DW-1:0] wbi_dat_o,
  output logic          wbi_ack_o,
  input  logic          wbd_cyc_i,
  input  logic          wbd_stb_i,
  input  logic          wbd_we_i,
  input  logic [DW/8-1:0] wbd_sel_i,
  input  logic [AW-1:0] wbd_adr_i,
  input  logic [DW-1:0] wbd_dat_i,
  output logic [DW-1:0] wbd_dat_o,
  output logic          wbd_ack_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic          wbs_we_o,
  output logic [DW/8-1:0] wbs_sel_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic [DW-1:0] wbs_dat_o,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  output logic [1:0]    grant_o
`ifdef MOXIE_ARB_TIMEOUT_EN
  ,
  output logic          wbi_err_o,
  output logic          wbd_err_o
`endif
);

  localparam int SW = DW / 8;

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       gnt_i, gnt_d;
  logic       tmo;

  assign gnt_i = (state_q == ARB_GNT_I);
  assign gnt_d = (state_q == ARB_GNT_D);

`ifdef MOXIE_ARB_TIMEOUT_EN
  logic wd_clr;
  logic wd_stall;

  assign wd_clr   = (state_q == ARB_IDLE) || (state_d != state_q) || wbs_ack_i;
  assign wd_stall = wbs_stb_o && !wbs_ack_i;

  moxie_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .stall_i  (wd_stall),
    .expired_o(tmo)
  );

  assign wbi_err_o = gnt_i && tmo;
  assign wbd_err_o = gnt_d && tmo;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo = 1'b0;
`endif

  // last_q: 0 = I granted last, 1 = D granted last
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (wbi_cyc_i && wbd_cyc_i)
          state_d = last_q ? ARB_GNT_I : ARB_GNT_D;
        else if (wbi_cyc_i)
          state_d = ARB_GNT_I;
        else if (wbd_cyc_i)
          state_d = ARB_GNT_D;
      end
      ARB_GNT_I: begin
        if (!wbi_cyc_i || tmo) begin
          last_d  = 1'b0;
          state_d = (wbd_cyc_i && !tmo) ? ARB_GNT_D : ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (!wbd_cyc_i || tmo) begin
          last_d  = 1'b1;
          state_d = (wbi_cyc_i && !tmo) ? ARB_GNT_I : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    if (gnt_i) begin
      wbs_cyc_o = wbi_cyc_i && !tmo;
      wbs_stb_o = wbi_stb_i && !tmo;
      wbs_sel_o = {SW{1'b1}};
      wbs_adr_o = wbi_adr_i;
    end else if (gnt_d) begin
      wbs_cyc_o = wbd_cyc_i && !tmo;
      wbs_stb_o = wbd_stb_i && !tmo;
      wbs_we_o  = wbd_we_i;
      wbs_sel_o = wbd_sel_i;
      wbs_adr_o = wbd_adr_i;
      wbs_dat_o = wbd_dat_i;
    end
  end

  assign wbi_ack_o = gnt_i && wbs_ack_i;
  assign wbd_ack_o = gnt_d && wbs_ack_i;
  assign wbi_dat_o = gnt_i ? wbs_dat_i : '0;
  assign wbd_dat_o = gnt_d ? wbs_dat_i : '0;

  assign grant_o[ARB_I] = gnt_i;
  assign grant_o[ARB_D] = gnt_d;

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Directed bench for moxie_wb_arbiter.
// Define MOXIE_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_moxie_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_cyc, i_stb;
  logic [31:0] i_adr;
  logic [31:0] i_dat;
  logic        i_ack;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_adr, d_wdat;
  logic [31:0] d_rdat;
  logic        d_ack;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic [31:0] s_rdat;
  logic        s_ack;
  logic [1:0]  grant;
`ifdef MOXIE_ARB_TIMEOUT_EN
  logic        i_err, d_err;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  moxie_wb_arbiter #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wbi_cyc_i(i_cyc),
    .wbi_stb_i(i_stb),
    .wbi_adr_i(i_adr),
    .wbi_dat_o(i_dat),
    .wbi_ack_o(i_ack),
    .wbd_cyc_i(d_cyc),
    .wbd_stb_i(d_stb),
    .wbd_we_i (d_we),
    .wbd_sel_i(d_sel),
    .wbd_adr_i(d_adr),
    .wbd_dat_i(d_wdat),
    .wbd_dat_o(d_rdat),
    .wbd_ack_o(d_ack),
    .wbs_cyc_o(s_cyc),
    .wbs_stb_o(s_stb),
    .wbs_we_o (s_we),
    .wbs_sel_o(s_sel),
    .wbs_adr_o(s_adr),
    .wbs_dat_o(s_wdat),
    .wbs_dat_i(s_rdat),
    .wbs_ack_i(s_ack),
    .grant_o  (grant)
`ifdef MOXIE_ARB_TIMEOUT_EN
    ,
    .wbi_err_o(i_err),
    .wbd_err_o(d_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_cyc = 0; i_stb = 0; i_adr = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_sel = '0;
    d_adr = '0; d_wdat = '0;
    s_rdat = 32'h1234_5678; s_ack = 1;

    // reset: all outputs low, slave ack ignored
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_cyc",   32'(s_cyc), 32'h0);
    chk("rst_sel",   32'(s_sel), 32'h0);
    chk("rst_iack",  32'(i_ack), 32'h0);
    chk("rst_ddat",  d_rdat,     32'h0);
    s_ack = 0;
    rst = 1;

    // simultaneous request after reset: D first, then I with no bubble
    i_cyc = 1; i_stb = 1; i_adr = 32'h1000;
    d_cyc = 1; d_stb = 1; d_adr = 32'h3000;
    #1;
    chk("lat_idle", 32'(grant), 32'h0);
    tick();
    chk("sim_gntd", 32'(grant), 32'h2);
    chk("sim_adrd", s_adr,      32'h3000);
    d_cyc = 0; d_stb = 0;
    #1;
    chk("sim_dcyc0", 32'(s_cyc), 32'h0);
    tick();
    chk("sim_gnti", 32'(grant), 32'h1);
    chk("sim_adri", s_adr,      32'h1000);
    i_cyc = 0; i_stb = 0;
    tick();
    chk("sim_idle", 32'(grant), 32'h0);

    // I-only read with ack, then cyc dropped alongside ack
    i_cyc = 1; i_stb = 1; i_adr = 32'h1000;
    tick();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_adr",   s_adr,      32'h1000);
    chk("rd_we",    32'(s_we),  32'h0);
    chk("rd_sel",   32'(s_sel), 32'hF);
    s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    #1;
    chk("rd_iack",  32'(i_ack), 32'h1);
    chk("rd_idat",  i_dat,      32'hDEAD_BEEF);
    chk("rd_dack",  32'(d_ack), 32'h0);
    chk("rd_ddat",  d_rdat,     32'h0);
    i_cyc = 0; i_stb = 0;
    #1;
    chk("rd_ack_drop", 32'(i_ack), 32'h1);
    tick();
    s_ack = 0;
    chk("rd_idle", 32'(grant), 32'h0);

    // D write passes through unchanged, I sees no ack
    d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'b0011;
    d_adr = 32'h2004; d_wdat = 32'h0000_CAFE;
    tick();
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_we",    32'(s_we),  32'h1);
    chk("wr_sel",   32'(s_sel), 32'h3);
    chk("wr_adr",   s_adr,      32'h2004);
    chk("wr_dat",   s_wdat,     32'h0000_CAFE);
    s_ack = 1;
    #1;
    chk("wr_dack",  32'(d_ack), 32'h1);
    chk("wr_iack",  32'(i_ack), 32'h0);
    d_cyc = 0; d_stb = 0; d_we = 0;
    tick();
    s_ack = 0;
    chk("wr_idle", 32'(grant), 32'h0);

    // locked RMW: D keeps cyc through an stb gap while I waits
    d_cyc = 1; d_stb = 1; d_adr = 32'h40; d_sel = 4'hF;
    tick();
    i_cyc = 1; i_stb = 1; i_adr = 32'h1080;
    s_ack = 1;
    tick();
    s_ack = 0; d_stb = 0;
    tick();
    chk("rmw_hold1", 32'(grant), 32'h2);
    chk("rmw_stb0",  32'(s_stb), 32'h0);
    chk("rmw_cyc1",  32'(s_cyc), 32'h1);
    tick();
    chk("rmw_hold2", 32'(grant), 32'h2);
    d_stb = 1; d_we = 1; s_ack = 1;
    tick();
    chk("rmw_hold3", 32'(grant), 32'h2);
    s_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    tick();
    chk("rmw_gnti", 32'(grant), 32'h1);
    chk("rmw_adri", s_adr,      32'h1080);
    i_cyc = 0; i_stb = 0;
    tick();

    // async reset in the middle of a D transfer
    d_cyc = 1; d_stb = 1; d_adr = 32'h50;
    tick();
    chk("ar_pre", 32'(grant), 32'h2);
    #2;
    rst = 0;
    s_ack = 1;
    #1;
    chk("ar_cyc",   32'(s_cyc), 32'h0);
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_dack",  32'(d_ack), 32'h0);
    s_ack = 0; d_cyc = 0; d_stb = 0;
    tick();
    rst = 1;

`ifdef MOXIE_ARB_TIMEOUT_EN
    // stalled slave: err after 4 stalled cycles, then IDLE, then I
    i_cyc = 1; i_stb = 1; i_adr = 32'h1100;
    d_cyc = 1; d_stb = 1; d_adr = 32'h60;
    tick();
    chk("to_gnt", 32'(grant), 32'h2);
    for (int k = 0; k < 4; k++) begin
      chk("to_noerr", 32'(d_err), 32'h0);
      tick();
    end
    chk("to_derr", 32'(d_err), 32'h1);
    chk("to_ierr", 32'(i_err), 32'h0);
    chk("to_cyc",  32'(s_cyc), 32'h0);
    tick();
    chk("to_idle", 32'(grant), 32'h0);
    chk("to_errlo", 32'(d_err), 32'h0);
    tick();
    chk("to_gnti", 32'(grant), 32'h1);
    i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench timed out");
    $fatal(1, "timeout");
  end

endmodule
